// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus/diag memory arbiter: width defaults,
// starvation limit default and the arbiter state encoding.
package bus_arb_pkg;

    localparam int ADDR_W_DEF       = 16;
    localparam int DATA_W_DEF       = 8;
    localparam int STARVE_LIMIT_DEF = 64;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CPU_RD     = 3'd1;
    localparam logic [2:0] ST_CPU_RD_CAP = 3'd2;
    localparam logic [2:0] ST_CPU_WR     = 3'd3;
    localparam logic [2:0] ST_DIAG_ISSUE = 3'd4;
    localparam logic [2:0] ST_DIAG_CAP   = 3'd5;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        CPU_RD     = ST_CPU_RD,
        CPU_RD_CAP = ST_CPU_RD_CAP,
        CPU_WR     = ST_CPU_WR,
        DIAG_ISSUE = ST_DIAG_ISSUE,
        DIAG_CAP   = ST_DIAG_CAP
    } arb_state_t;

endpackage

// File: rtl/bus_mem_arbiter_if.sv
// CPU bus, diag handshake and memory port bundle. The slave modport is the
// arbiter's view; the master modport is the CPU/diag/memory side.
interface bus_mem_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              cpu_sel;
    logic              cpu_rwbar;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_oe;
    logic              rdy;

    logic              diag_req;
    logic              diag_we;
    logic [ADDR_W-1:0] diag_addr;
    logic [DATA_W-1:0] diag_wdata;
    logic              diag_ack;
    logic [DATA_W-1:0] diag_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_sel, cpu_rwbar, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_oe, rdy,
        input  diag_req, diag_we, diag_addr, diag_wdata,
        output diag_ack, diag_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output cpu_sel, cpu_rwbar, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_oe, rdy,
        output diag_req, diag_we, diag_addr, diag_wdata,
        input  diag_ack, diag_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );

endinterface

// File: rtl/bus_mem_arbiter_phi2_sync.sv
// Two-flop synchronizer for the raw 6502 phi2 clock, with single-cycle
// rise/fall pulses derived from the synchronized level.
module phi2_sync (
    input  logic clk,
    input  logic rst,
    input  logic phi2,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sh <= '0;
        else      sh <= {sh[1:0], phi2};
    end

    assign level = sh[1];
    assign rise  = sh[1] & ~sh[2];
    assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/bus_mem_arbiter.sv
// Arbitrates one single-port memory between phi2-timed 6502 accesses and the
// SPI diag req/ack port. Define ARB_CPU_HALT_EN to enable RDY starvation control.
module bus_mem_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic              clk,
    input logic              rst,
    input logic              phi2,
    bus_mem_arbiter_if.slave bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..255");
    end

    logic phi2_lvl, phi2_rise, phi2_fall;

    phi2_sync u_phi2_sync (
        .clk   (clk),
        .rst   (rst),
        .phi2  (phi2),
        .level (phi2_lvl),
        .rise  (phi2_rise),
        .fall  (phi2_fall)
    );

    arb_state_t        state;
    logic [DATA_W-1:0] wdata_smp, wr_data, cpu_rdata_q, diag_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] addr_q, rd_addr, wr_addr, mem_addr_q;
    logic              sel_q, rwbar_q, rd_pend, wr_pend, diag_we_q;
    logic              cpu_oe_q, mem_we_q, mem_re_q, rdy_q, halted, diag_ack;
    logic              rd_hit, wr_hit, rd_req, wr_req, idle;
    logic              grant_rd, grant_wr, grant_diag;
    logic [ADDR_W-1:0] rd_addr_n, wr_addr_n;
    logic [DATA_W-1:0] wr_data_n;

    // A fresh edge is granted in the same cycle it is seen, so a diag request
    // arriving together with a CPU edge cannot slip in ahead of it.
    always_comb begin
        rd_hit     = phi2_rise & bus.cpu_sel & bus.cpu_rwbar;
        wr_hit     = phi2_fall & sel_q & ~rwbar_q;
        rd_req     = rd_pend | rd_hit;
        wr_req     = wr_pend | wr_hit;
        rd_addr_n  = rd_pend ? rd_addr : bus.cpu_addr;
        wr_addr_n  = wr_pend ? wr_addr : addr_q;
        wr_data_n  = wr_pend ? wr_data : wdata_smp;
        idle       = (state == IDLE);
        grant_wr   = idle & wr_req;
        grant_rd   = idle & ~wr_req & rd_req & ~(halted & bus.diag_req);
        grant_diag = idle & ~wr_req & bus.diag_req & (~rd_req | halted);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdata_smp <= '0;
            sel_q     <= 1'b0;
            rwbar_q   <= 1'b1;
            addr_q    <= '0;
            rd_pend   <= 1'b0;
            rd_addr   <= '0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            if (phi2_lvl) wdata_smp <= bus.cpu_wdata;
            if (phi2_rise) begin
                sel_q   <= bus.cpu_sel;
                rwbar_q <= bus.cpu_rwbar;
                addr_q  <= bus.cpu_addr;
            end
            if (grant_rd) rd_pend <= 1'b0;
            else if (rd_hit) begin
                rd_pend <= 1'b1;
                rd_addr <= bus.cpu_addr;
            end
            if (grant_wr) wr_pend <= 1'b0;
            else if (wr_hit) begin
                wr_pend <= 1'b1;
                wr_addr <= addr_q;
                wr_data <= wdata_smp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            diag_rdata_q <= '0;
            diag_we_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        mem_addr_q  <= wr_addr_n;
                        mem_wdata_q <= wr_data_n;
                        mem_we_q    <= 1'b1;
                        state       <= CPU_WR;
                    end else if (grant_rd) begin
                        mem_addr_q <= rd_addr_n;
                        mem_re_q   <= 1'b1;
                        state      <= CPU_RD;
                    end else if (grant_diag) begin
                        mem_addr_q  <= bus.diag_addr;
                        mem_wdata_q <= bus.diag_wdata;
                        mem_we_q    <= bus.diag_we;
                        mem_re_q    <= ~bus.diag_we;
                        diag_we_q   <= bus.diag_we;
                        state       <= DIAG_ISSUE;
                    end
                end
                CPU_RD: begin
                    mem_re_q <= 1'b0;
                    state    <= CPU_RD_CAP;
                end
                CPU_RD_CAP: begin
                    cpu_rdata_q <= bus.mem_rdata;
                    state       <= IDLE;
                end
                CPU_WR: begin
                    mem_we_q <= 1'b0;
                    state    <= IDLE;
                end
                DIAG_ISSUE: begin
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    state    <= DIAG_CAP;
                end
                DIAG_CAP: begin
                    if (!diag_we_q) diag_rdata_q <= bus.mem_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output enable only rises while phi2 is still high, so a late capture
    // never drives the bus into phi1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     cpu_oe_q <= 1'b0;
        else if (state == CPU_RD_CAP) cpu_oe_q <= phi2_lvl;
        else if (phi2_fall)           cpu_oe_q <= 1'b0;
    end

    assign diag_ack = (state == DIAG_CAP);

`ifdef ARB_CPU_HALT_EN
    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);
    logic [7:0] starve_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            rdy_q      <= 1'b1;
        end else if (diag_ack || !bus.diag_req) begin
            starve_cnt <= '0;
            rdy_q      <= 1'b1;
        end else begin
            if (starve_cnt != '1) starve_cnt <= starve_cnt + 8'd1;
            if (starve_cnt >= LIMIT_M1) rdy_q <= 1'b0;
        end
    end

    assign halted = ~rdy_q;
`else
    assign rdy_q  = 1'b1;
    assign halted = 1'b0;
`endif

    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_oe     = cpu_oe_q;
    assign bus.rdy        = rdy_q;
    assign bus.diag_ack   = diag_ack;
    assign bus.diag_rdata = (diag_ack && !diag_we_q) ? bus.mem_rdata : diag_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;

endmodule

// File: tb/tb_bus_mem_arbiter.sv
// Directed bench for bus_mem_arbiter: CPU read/write, diag access, collision,
// reset abort, and (with ARB_CPU_HALT_EN) RDY starvation.
module tb_bus_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LIM = 8;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic phi2 = 1'b0;

    int checks   = 0;
    int failures = 0;

    bus_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .phi2 (phi2),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic        load_en   = 1'b0;
    logic [15:0] load_addr = '0;
    logic [7:0]  load_data = '0;

    always @(posedge clk) begin
        if (load_en)         mem[load_addr] <= load_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re)      bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, oe_at, ack_at, strobes, oe_seen, k, cpu_re;
        logic seen, rdy_at_ack;
        logic [15:0] wa;
        logic [7:0]  wd, rcap;

        bus.cpu_sel = 1'b0; bus.cpu_rwbar = 1'b1; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.diag_req = 1'b0; bus.diag_we = 1'b0; bus.diag_addr = '0; bus.diag_wdata = '0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_cpu_rdata",  bus.cpu_rdata, 0);
        chk("rst_cpu_oe",     bus.cpu_oe, 0);
        chk("rst_rdy",        bus.rdy, 1);
        chk("rst_diag_ack",   bus.diag_ack, 0);
        chk("rst_diag_rdata", bus.diag_rdata, 0);
        chk("rst_mem_we",     bus.mem_we, 0);
        chk("rst_mem_re",     bus.mem_re, 0);
        chk("rst_mem_addr",   bus.mem_addr, 0);
        chk("rst_mem_wdata",  bus.mem_wdata, 0);
        rst = 1'b1;
        load(16'hF000, 8'hA9);
        load(16'h1234, 8'h77);
        load(16'h0300, 8'hEE);
        load(16'h0200, 8'h00);

        // CPU read of 0xF000
        @(negedge clk);
        bus.cpu_sel = 1'b1; bus.cpu_rwbar = 1'b1; bus.cpu_addr = 16'hF000; phi2 = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk); n++;
            if (bus.cpu_oe) seen = 1'b1;
        end
        chk("rd_oe_seen", seen, 1);
        chk("rd_latency_le6", n <= 6, 1);
        chk("rd_data", bus.cpu_rdata, 8'hA9);
        repeat (4) @(negedge clk);
        phi2 = 1'b0;
        @(negedge clk);
        chk("rd_oe_hold", bus.cpu_oe, 1);
        repeat (3) @(negedge clk);
        chk("rd_oe_drop", bus.cpu_oe, 0);
        bus.cpu_sel = 1'b0;
        repeat (6) @(negedge clk);

        // CPU write 0x5C to 0x0200
        bus.cpu_sel = 1'b1; bus.cpu_rwbar = 1'b0; bus.cpu_addr = 16'h0200; bus.cpu_wdata = 8'h5C;
        phi2 = 1'b1;
        strobes = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_we) strobes++;
        end
        chk("wr_no_early_we", strobes, 0);
        phi2 = 1'b0;
        strobes = 0; wa = '0; wd = '0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_we) begin strobes++; wa = bus.mem_addr; wd = bus.mem_wdata; end
        end
        chk("wr_single_we", strobes, 1);
        chk("wr_addr", wa, 16'h0200);
        chk("wr_data", wd, 8'h5C);
        chk("wr_mem", mem[16'h0200], 8'h5C);
        bus.cpu_sel = 1'b0; bus.cpu_rwbar = 1'b1;

        // deselected cycle does nothing
        bus.cpu_addr = 16'hF000; phi2 = 1'b1;
        strobes = 0; oe_seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 10) phi2 = 1'b0;
            if (bus.mem_we || bus.mem_re) strobes++;
            if (bus.cpu_oe) oe_seen++;
        end
        chk("nosel_strobes", strobes, 0);
        chk("nosel_oe", oe_seen, 0);

        // diag read in idle
        bus.diag_req = 1'b1; bus.diag_we = 1'b0; bus.diag_addr = 16'h1234;
        @(negedge clk);
        chk("dr_ack_early", bus.diag_ack, 0);
        @(negedge clk);
        chk("dr_ack", bus.diag_ack, 1);
        chk("dr_data", bus.diag_rdata, 8'h77);
        chk("dr_rdy", bus.rdy, 1);
        bus.diag_req = 1'b0;
        @(negedge clk);
        chk("dr_ack_pulse", bus.diag_ack, 0);

        // diag write 0x3C to 0x4000
        bus.diag_req = 1'b1; bus.diag_we = 1'b1; bus.diag_addr = 16'h4000; bus.diag_wdata = 8'h3C;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (bus.diag_ack) begin seen = 1'b1; bus.diag_req = 1'b0; end
        end
        bus.diag_req = 1'b0;
        @(negedge clk);
        chk("dw_ack_seen", seen, 1);
        chk("dw_mem", mem[16'h4000], 8'h3C);
        repeat (3) @(negedge clk);

        // collision: diag request in the cycle the synced rise appears
        bus.cpu_sel = 1'b1; bus.cpu_rwbar = 1'b1; bus.cpu_addr = 16'hF000; phi2 = 1'b1;
        repeat (2) @(negedge clk);
        bus.diag_req = 1'b1; bus.diag_we = 1'b0; bus.diag_addr = 16'h1234;
        oe_at = 0; ack_at = 0; rcap = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.cpu_oe && oe_at == 0) oe_at = i;
            if (bus.diag_ack && ack_at == 0) begin
                ack_at = i; rcap = bus.diag_rdata; bus.diag_req = 1'b0;
            end
        end
        chk("col_both_served", (oe_at != 0) && (ack_at != 0), 1);
        chk("col_cpu_first", oe_at < ack_at, 1);
        chk("col_cpu_data", bus.cpu_rdata, 8'hA9);
        chk("col_diag_data", rcap, 8'h77);
        phi2 = 1'b0; bus.cpu_sel = 1'b0;
        repeat (6) @(negedge clk);

        // reset while the CPU write strobe is up
        bus.cpu_sel = 1'b1; bus.cpu_rwbar = 1'b0; bus.cpu_addr = 16'h0300; bus.cpu_wdata = 8'h11;
        phi2 = 1'b1;
        repeat (10) @(negedge clk);
        phi2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_we", bus.mem_we, 1);
        rst = 1'b0;
        #1;
        chk("rstw_mem_we",    bus.mem_we, 0);
        chk("rstw_mem_re",    bus.mem_re, 0);
        chk("rstw_mem_addr",  bus.mem_addr, 0);
        chk("rstw_mem_wdata", bus.mem_wdata, 0);
        chk("rstw_cpu_oe",    bus.cpu_oe, 0);
        chk("rstw_cpu_rdata", bus.cpu_rdata, 0);
        chk("rstw_rdy",       bus.rdy, 1);
        chk("rstw_diag_ack",  bus.diag_ack, 0);
        bus.cpu_sel = 1'b0; bus.cpu_rwbar = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        strobes = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_we) strobes++;
        end
        chk("rstw_no_late_we", strobes, 0);
        chk("rstw_mem_kept", mem[16'h0300], 8'hEE);

`ifdef ARB_CPU_HALT_EN
        // starvation: a read on every 3-clk phi2 cycle keeps the arbiter busy
        bus.cpu_sel = 1'b1; bus.cpu_rwbar = 1'b1; bus.cpu_addr = 16'hF000;
        k = 0; phi2 = 1'b1;
        @(negedge clk); k++; phi2 = (k % 3 != 2);
        @(negedge clk); k++; phi2 = (k % 3 != 2);
        bus.diag_req = 1'b1; bus.diag_we = 1'b0; bus.diag_addr = 16'h1234;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); k++; phi2 = (k % 3 != 2);
            if (i == 7) chk("starve_rdy_hi", bus.rdy, 1);
            if (i == 8) chk("starve_rdy_lo", bus.rdy, 0);
        end
        seen = 1'b0; cpu_re = 0; rdy_at_ack = 1'b1; rcap = '0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk); k++; phi2 = (k % 3 != 2);
            if (bus.mem_re && bus.mem_addr == 16'hF000) cpu_re++;
            if (bus.diag_ack) begin
                seen = 1'b1; rdy_at_ack = bus.rdy; rcap = bus.diag_rdata; bus.diag_req = 1'b0;
            end
        end
        chk("starve_ack_seen", seen, 1);
        chk("starve_diag_first", cpu_re, 0);
        chk("starve_rdy_at_ack", rdy_at_ack, 0);
        chk("starve_diag_data", rcap, 8'h77);
        @(negedge clk); k++; phi2 = (k % 3 != 2);
        chk("starve_rdy_release", bus.rdy, 1);
        phi2 = 1'b0; bus.cpu_sel = 1'b0;
        repeat (8) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
